// File: rtl/fp_exp_alu_if.sv
// Request/result bundle between the operand unpack stage, the exponent ALU
// and the mantissa datapath controller.
interface fp_exp_alu_if #(
    parameter int unsigned EXP_W = 8
);
    logic             start;
    logic [1:0]       op;
    logic [EXP_W-1:0] exp_a;
    logic [EXP_W-1:0] exp_b;
    logic             busy;
    logic             done;
    logic [EXP_W-1:0] result;
    logic [EXP_W-1:0] shift_amt;
    logic             swap;
    logic             overflow;
    logic             underflow;
    logic             illegal;

    modport master (
        output start, op, exp_a, exp_b,
        input  busy, done, result, shift_amt, swap, overflow, underflow, illegal
    );

    modport slave (
        input  start, op, exp_a, exp_b,
        output busy, done, result, shift_amt, swap, overflow, underflow, illegal
    );
endinterface

// File: rtl/fp_exp_alu.sv
// Exponent datapath: add/sub alignment, biased sum (MUL) and biased
// difference (DIV), with a start/done handshake and saturating range check.
module fp_exp_alu #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned BIAS  = 127
) (
    input logic        clk,
    input logic        rst_n,
    fp_exp_alu_if.slave bus
);
    localparam int unsigned ACC_W = EXP_W + 2;
    localparam logic signed [ACC_W-1:0] BIAS_X = signed'(ACC_W'(BIAS));
    localparam logic signed [ACC_W-1:0] MAX_X  = signed'(ACC_W'((1 << EXP_W) - 1));

    typedef enum logic [1:0] {IDLE, S1, S2, DONE} state_t;
    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_MUL = 2'b01, OP_DIV = 2'b10, OP_ILL = 2'b11} op_t;

    state_t                  state, state_n;
    op_t                     op_q;
    logic [EXP_W-1:0]        a_q, b_q;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_s1, acc_s2, a_x, b_x;
    logic [EXP_W-1:0]        result, shift_amt;
    logic                    swap, overflow, underflow, illegal;
    logic                    accept;

    assign accept = bus.start && (state == IDLE || state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (bus.start) state_n = S1;
            S1:   state_n = (op_q == OP_MUL || op_q == OP_DIV) ? S2 : DONE;
            S2:   state_n = DONE;
            DONE: state_n = bus.start ? S1 : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        a_x    = signed'({2'b00, a_q});
        b_x    = signed'({2'b00, b_q});
        acc_s1 = (op_q == OP_MUL) ? a_x + b_x : a_x - b_x;
        acc_s2 = (op_q == OP_MUL) ? acc - BIAS_X : acc + BIAS_X;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= OP_ADD;
            acc       <= '0;
            result    <= '0;
            shift_amt <= '0;
            swap      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            illegal   <= 1'b0;
        end else if (accept) begin
            a_q       <= bus.exp_a;
            b_q       <= bus.exp_b;
            op_q      <= op_t'(bus.op);
            acc       <= '0;
            result    <= '0;
            shift_amt <= '0;
            swap      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            illegal   <= 1'b0;
        end else if (state == S1) begin
            acc <= acc_s1;
            if (op_q == OP_ADD) begin
                // Sign of a-b picks the larger exponent and the shift direction.
                if (acc_s1[ACC_W-1]) begin
                    swap      <= 1'b1;
                    shift_amt <= EXP_W'(-acc_s1);
                    result    <= b_q;
                end else begin
                    shift_amt <= EXP_W'(acc_s1);
                    result    <= a_q;
                end
            end else if (op_q == OP_ILL) begin
                illegal <= 1'b1;
            end
        end else if (state == S2) begin
            acc <= acc_s2;
            if (acc_s2 >= MAX_X) begin
                result   <= '1;
                overflow <= 1'b1;
            end else if (acc_s2[ACC_W-1] || acc_s2 == '0) begin
                result    <= '0;
                underflow <= 1'b1;
            end else begin
                result <= acc_s2[EXP_W-1:0];
            end
        end
    end

    assign bus.busy      = (state == S1) || (state == S2);
    assign bus.done      = (state == DONE);
    assign bus.result    = result;
    assign bus.shift_amt = shift_amt;
    assign bus.swap      = swap;
    assign bus.overflow  = overflow;
    assign bus.underflow = underflow;
    assign bus.illegal   = illegal;
endmodule

// File: tb/tb_fp_exp_alu.sv
// Directed bench for fp_exp_alu: single and double width instances driven
// through one shared stimulus path selected by use11.
module tb_fp_exp_alu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_exp_alu_if #(.EXP_W(8))  bus8();
    fp_exp_alu_if #(.EXP_W(11)) bus11();

    fp_exp_alu #(.EXP_W(8),  .BIAS(127))  u8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    fp_exp_alu #(.EXP_W(11), .BIAS(1023)) u11 (.clk(clk), .rst_n(rst_n), .bus(bus11));

    logic        use11   = 1'b0;
    logic        start_d = 1'b0;
    logic [1:0]  op_d    = 2'b00;
    logic [10:0] a_d     = '0;
    logic [10:0] b_d     = '0;

    assign bus8.start  = start_d & ~use11;
    assign bus8.op     = op_d;
    assign bus8.exp_a  = a_d[7:0];
    assign bus8.exp_b  = b_d[7:0];
    assign bus11.start = start_d & use11;
    assign bus11.op    = op_d;
    assign bus11.exp_a = a_d;
    assign bus11.exp_b = b_d;

    logic        s_busy, s_done, s_swap, s_ov, s_un, s_il;
    logic [10:0] s_res, s_sh;
    assign s_busy = use11 ? bus11.busy      : bus8.busy;
    assign s_done = use11 ? bus11.done      : bus8.done;
    assign s_swap = use11 ? bus11.swap      : bus8.swap;
    assign s_ov   = use11 ? bus11.overflow  : bus8.overflow;
    assign s_un   = use11 ? bus11.underflow : bus8.underflow;
    assign s_il   = use11 ? bus11.illegal   : bus8.illegal;
    assign s_res  = use11 ? bus11.result    : {3'b000, bus8.result};
    assign s_sh   = use11 ? bus11.shift_amt : {3'b000, bus8.shift_amt};

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // no_wait: present the op at the current negedge (back-to-back from DONE);
    // hold: leave start high through the operation.
    task automatic run(input string tag, input logic [1:0] op, input int a, input int b,
                       input int lat, input int res, input int sh, input int sw,
                       input int ov, input int un, input int il,
                       input bit no_wait, input bit hold);
        int n      = 0;
        int busy_n = 0;
        bit both   = 1'b0;
        if (!no_wait) @(negedge clk);
        start_d = 1'b1;
        op_d    = op;
        a_d     = a[10:0];
        b_d     = b[10:0];
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check({tag, " clr"}, {6'd0, s_res, s_sh, s_swap, s_ov, s_un, s_il}, 32'd0);
                if (!hold) start_d = 1'b0;
            end
            if (s_busy) busy_n++;
            if (s_busy && s_done) both = 1'b1;
        end while (!s_done && n < 10);
        check({tag, " lat"},  n, lat);
        check({tag, " busy"}, busy_n, lat - 1);
        check({tag, " b&d"},  {31'd0, both}, 32'd0);
        check({tag, " res"},  {21'd0, s_res}, res);
        check({tag, " sh"},   {21'd0, s_sh}, sh);
        check({tag, " flg"},  {28'd0, s_swap, s_ov, s_un, s_il}, {sw[0], ov[0], un[0], il[0]});
    endtask

    initial begin : stim
        int dones;
        #2;
        check("rst out", {4'd0, bus8.busy, bus8.done, bus8.result, bus8.shift_amt,
                          bus8.swap, bus8.overflow, bus8.underflow, bus8.illegal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //   tag        op     a    b   lat res  sh sw ov un il nw hold
        run("add_gt",   2'b00, 130, 127, 2, 130,  3, 0, 0, 0, 0, 0, 0);
        run("add_lt",   2'b00, 100, 120, 2, 120, 20, 1, 0, 0, 0, 0, 1);
        run("b2b_mul",  2'b01, 130, 129, 3, 132,  0, 0, 0, 0, 0, 1, 0);
        run("div",      2'b10, 127, 130, 3, 124,  0, 0, 0, 0, 0, 0, 0);
        run("mul_ov",   2'b01, 200, 200, 3, 255,  0, 0, 1, 0, 0, 0, 0);
        run("mul_un",   2'b01,  10,  20, 3,   0,  0, 0, 0, 1, 0, 0, 0);
        run("div_un",   2'b10,   1, 200, 3,   0,  0, 0, 0, 1, 0, 0, 0);
        run("mul_254",  2'b01, 127, 254, 3, 254,  0, 0, 0, 0, 0, 0, 0);
        run("mul_255",  2'b01, 128, 254, 3, 255,  0, 0, 1, 0, 0, 0, 0);
        run("div_zero", 2'b10,   0, 127, 3,   0,  0, 0, 0, 1, 0, 0, 0);
        run("mul_one",  2'b01,  64,  64, 3,   1,  0, 0, 0, 0, 0, 0, 0);
        run("add_eq",   2'b00,  77,  77, 2,  77,  0, 0, 0, 0, 0, 0, 0);
        run("illegal",  2'b11,   5,   6, 2,   0,  0, 0, 0, 0, 1, 0, 0);

        // Second start request while in S1 must not spawn another operation.
        @(negedge clk);
        start_d = 1'b1; op_d = 2'b01; a_d = 11'd64; b_d = 11'd64;
        @(negedge clk);
        a_d = 11'd200; b_d = 11'd200;
        @(negedge clk);
        start_d = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (s_done) begin
                dones++;
                check("ign res", {21'd0, s_res}, 32'd1);
            end
        end
        check("ign dones", dones, 1);

        // Asynchronous reset during S2 of a MUL.
        start_d = 1'b1; op_d = 2'b01; a_d = 11'd130; b_d = 11'd129;
        @(negedge clk);
        start_d = 1'b0;
        @(negedge clk);
        check("pre rst busy", {31'd0, s_busy}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid rst out", {4'd0, s_busy, s_done, s_res, s_sh, s_swap, s_ov, s_un, s_il}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (s_done) dones++;
        end
        check("rst dones", dones, 0);

        use11 = 1'b1;
        run("w11_mul",  2'b01, 1030, 1020, 3, 1027, 0, 0, 0, 0, 0, 0, 0);
        run("w11_ov",   2'b01, 2000, 2000, 3, 2047, 0, 0, 1, 0, 0, 0, 0);
        run("w11_add",  2'b00,  900, 1000, 2, 1000, 100, 1, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
